arc4_encrypt: RTL and testbench
===============================

Name: arc4_encrypt

Overview:
- ARC4 encryptor: reads a length-prefixed plaintext from the PT memory and writes the ciphertext to the CT memory.
- The CT memory it fills has the same layout the task3 decryptor consumes: byte 0 = length, bytes 1..len = ciphertext.
- Runs after init+ksa have left the key-scheduled state in S memory; shares that S memory through a mux owned by the top level.
- Sits beside the task3 decrypt datapath, driven by the same en/rdy handshake.

Parameters:
- DROP_N, 0, number of initial keystream bytes discarded (used only with ARC4_DROP_EN)

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  idle/ready flag
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- pt_addr  out  8  PT memory address
- pt_rddata  in  8  PT memory read data
- ct_addr  out  8  CT memory address
- ct_wrdata  out  8  CT memory write data
- ct_wren  out  1  CT memory write enable

Behaviour:
- Reset values: rdy=1; s_wren=0; ct_wren=0; all addresses and wrdata=0; i=j=k=0; FSM in IDLE.
- Memory timing: all memories are altsyncram with registered address. Read data is valid the cycle after the address is driven; every read state is followed by a WAIT state.
- Handshake:
  - en=1 while rdy=1 starts a run; rdy=0 from the next edge until DONE.
  - en is ignored while rdy=0.
  - rdy returns to 1 one cycle after the last CT write; en may be re-asserted in that same cycle.
- FSM states, in order:
  - IDLE
  - RD_LEN, WT_LEN: pt_addr=0.
  - WR_LEN: ct[0]=len.
  - RD_SI, WT_SI: i=(i+1) mod 256.
  - RD_SJ, WT_SJ: j=(j+si) mod 256.
  - WR_SI: S[i]=sj.
  - WR_SJ: S[j]=si.
  - RD_PAD, WT_PAD: s_addr=(si+sj) mod 256 and pt_addr=k, issued in the same cycle.
  - WR_CT: ct[k]=pad XOR pt[k]; k++. If k==len go to DONE, else go to RD_SI.
  - DONE: rdy=1, then IDLE.
- Arithmetic: all index arithmetic is 8-bit and wraps silently. si and sj are latched in 8-bit registers.
- Start of run: i, j, k are cleared on every start. k runs 1..len.
- len=0: ct[0]=0 is written, then DONE. No S access occurs.
- len=255: k reaches 255 with no overflow; ct[255] is the last write.
- i==j: both swap writes target the same address with the same value; this is legal and needs no special case.
- Write enables: at most one wren is high per cycle, and only in WR_* states.
- Reset mid-run: immediate return to IDLE with wrens low. S and CT contents are then undefined; the caller must re-run init+ksa.

Optional Feature:
- Macro: ARC4_DROP_EN.
- Defined: after WR_LEN, DROP_N full PRGA steps (RD_SI..WR_SJ) run with no pad read and no CT write, before k=1. S and i, j advance normally. rdy stays low throughout.
- Undefined: no drop logic is compiled; DROP_N is ignored and the behaviour is identical to DROP_N=0.

Decomposition:
- Package arc4_pkg holds:
  - state enum typedef;
  - constants BYTE_W=8, MEM_DEPTH=256, LEN_ADDR=8'h00.
- No sub-module: one FSM plus the i, j, k, si, sj registers; swap and pad logic is too small to split.
- Top-level S-memory muxing between init, ksa and arc4_encrypt stays outside this block.

Test Plan:
- Known vector: S preloaded with the KSA result for key 24'h4B6579 ("Key"); PT = {09,"Plaintext"}; pulse en -> CT = 09 BB F3 16 E8 D9 40 AF 0A D3; rdy rises after the 10th CT write.
- Length zero: PT[0]=00 -> exactly one CT write (ct[0]=00), zero S writes, rdy back high within 5 cycles.
- Round trip: encrypt a 255-byte random PT, re-run ksa with the same key, run the task3 decryptor on CT -> output equals the original PT byte-for-byte; ct[255] written, no address wrap.
- Handshake: en held high across an entire run -> exactly one run occurs, and a second run starts only after rdy=1; en pulsed while rdy=0 -> no effect.
- Reset mid-run: assert rst_n=0 at k=4 -> same cycle rdy=1, s_wren=0, ct_wren=0; a new run after KSA reload produces correct CT.
- ARC4_DROP_EN with DROP_N=2: CT bytes equal the reference keystream bytes 3..n+2 XOR PT; ct[0] unchanged.

Source files
------------

// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arc4_pkg
//  Purpose  : Shared types and constants for the ARC4 encryptor.
//  Revision : 1.0  initial release
// ============================================================================
package arc4_pkg;

  localparam int         BYTE_W    = 8;
  localparam int         MEM_DEPTH = 256;
  localparam logic [7:0] LEN_ADDR  = 8'h00;

  // Every read state is followed by its WAIT state because the memories
  // register the address; read data shows up one cycle later.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_LEN = 4'd1,
    ST_WT_LEN = 4'd2,
    ST_WR_LEN = 4'd3,
    ST_RD_SI  = 4'd4,
    ST_WT_SI  = 4'd5,
    ST_RD_SJ  = 4'd6,
    ST_WT_SJ  = 4'd7,
    ST_WR_SI  = 4'd8,
    ST_WR_SJ  = 4'd9,
    ST_RD_PAD = 4'd10,
    ST_WT_PAD = 4'd11,
    ST_WR_CT  = 4'd12,
    ST_DONE   = 4'd13
  } state_t;

endpackage
`default_nettype wire

// File: rtl/arc4_encrypt.sv
`default_nettype none
// ============================================================================
//  Module   : arc4_encrypt
//  Purpose  : ARC4 PRGA encryptor. Reads a length-prefixed plaintext from PT
//             memory, combines it with the keystream taken from the
//             key-scheduled S memory and writes a length-prefixed ciphertext
//             to CT memory.
//  Options  : ARC4_DROP_EN - when defined, DROP_N keystream bytes are
//             generated and discarded before the first ciphertext byte.
//  Revision : 1.0  initial release
// ============================================================================
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int DROP_N = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [BYTE_W-1:0] s_addr,
  input  logic [BYTE_W-1:0] s_rddata,
  output logic [BYTE_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [BYTE_W-1:0] pt_addr,
  input  logic [BYTE_W-1:0] pt_rddata,
  output logic [BYTE_W-1:0] ct_addr,
  output logic [BYTE_W-1:0] ct_wrdata,
  output logic              ct_wren
);

  // The drop counter is 8 bits wide, so larger values cannot be honoured.
  if (DROP_N < 0 || DROP_N >= MEM_DEPTH) begin : g_drop_n_check
    $error("arc4_encrypt: DROP_N out of range");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BYTE_W-1:0] r_i, r_j, r_k, r_len;
  logic [BYTE_W-1:0] r_si, r_sj, r_pad, r_pt;
  logic              w_drop_pending;

`ifdef ARC4_DROP_EN
  logic [BYTE_W-1:0] r_drop;

  // Remaining discarded PRGA steps; loaded once the length is known.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (r_state == ST_WR_LEN) begin
      r_drop <= BYTE_W'(DROP_N);
    end else if (r_state == ST_WR_SJ && w_drop_pending) begin
      r_drop <= r_drop - 8'd1;
    end
  end

  assign w_drop_pending = (r_drop != '0);
`else
  assign w_drop_pending = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Index and latched-data registers; each is updated in the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_len <= '0;
      r_si  <= '0;
      r_sj  <= '0;
      r_pad <= '0;
      r_pt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (en) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
          end
        end
        ST_WT_LEN: r_len <= pt_rddata;
        ST_WR_LEN: r_k   <= 8'd1;       // ciphertext bytes live at 1..len
        ST_RD_SI:  r_i   <= r_i + 8'd1;
        ST_WT_SI:  r_si  <= s_rddata;
        ST_RD_SJ:  r_j   <= r_j + r_si;
        ST_WT_SJ:  r_sj  <= s_rddata;
        ST_WT_PAD: begin
          r_pad <= s_rddata;
          r_pt  <= pt_rddata;
        end
        // Hold k at len on the last byte so len=255 never wraps.
        ST_WR_CT: if (r_k != r_len) r_k <= r_k + 8'd1;
        default: ;
      endcase
    end
  end

  // Next-state and memory-port decode; ports idle at zero by default.
  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    s_addr      = '0;
    s_wrdata    = '0;
    s_wren      = 1'b0;
    pt_addr     = '0;
    ct_addr     = '0;
    ct_wrdata   = '0;
    ct_wren     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        rdy         = 1'b1;
        w_state_nxt = en ? ST_RD_LEN : ST_IDLE;
      end
      ST_RD_LEN: begin
        pt_addr     = LEN_ADDR;
        w_state_nxt = ST_WT_LEN;
      end
      ST_WT_LEN: begin
        pt_addr     = LEN_ADDR;
        w_state_nxt = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        ct_addr     = LEN_ADDR;
        ct_wrdata   = r_len;
        ct_wren     = 1'b1;
        w_state_nxt = (r_len == '0) ? ST_DONE : ST_RD_SI;
      end
      ST_RD_SI: begin
        s_addr      = r_i + 8'd1;
        w_state_nxt = ST_WT_SI;
      end
      ST_WT_SI: begin
        s_addr      = r_i;
        w_state_nxt = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        s_addr      = r_j + r_si;
        w_state_nxt = ST_WT_SJ;
      end
      ST_WT_SJ: begin
        s_addr      = r_j;
        w_state_nxt = ST_WR_SI;
      end
      ST_WR_SI: begin
        s_addr      = r_i;
        s_wrdata    = r_sj;
        s_wren      = 1'b1;
        w_state_nxt = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        s_addr      = r_j;
        s_wrdata    = r_si;
        s_wren      = 1'b1;
        w_state_nxt = w_drop_pending ? ST_RD_SI : ST_RD_PAD;
      end
      ST_RD_PAD, ST_WT_PAD: begin
        s_addr      = r_si + r_sj;
        pt_addr     = r_k;
        w_state_nxt = (r_state == ST_RD_PAD) ? ST_WT_PAD : ST_WR_CT;
      end
      ST_WR_CT: begin
        ct_addr     = r_k;
        ct_wrdata   = r_pad ^ r_pt;
        ct_wren     = 1'b1;
        w_state_nxt = (r_k == r_len) ? ST_DONE : ST_RD_SI;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_arc4_encrypt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arc4_encrypt
//  Purpose  : Directed self-checking bench for arc4_encrypt with behavioural
//             S/PT/CT memories that register their read address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arc4_encrypt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] s_q = 8'h00, pt_q = 8'h00;

  int total = 0;
  int bad   = 0;

  // Write-activity counters; tests look at their deltas.
  int n_ct_wr = 0, n_len_wr = 0, n_ct255 = 0, n_s_wr = 0, n_both = 0;

  // "Key" -> RC4 keystream XOR "Plaintext"
  logic [7:0] kv_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] orig  [256];

  always #5 clk = ~clk;

  arc4_encrypt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .ct_addr  (ct_addr),
    .ct_wrdata(ct_wrdata),
    .ct_wren  (ct_wren)
  );

  // Synchronous-address memories: data follows the address one cycle later.
  always @(posedge clk) begin
    s_q  <= s_addr;
    pt_q <= pt_addr;
    if (s_wren)  s_mem[s_addr]   <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    if (ct_wren) n_ct_wr <= n_ct_wr + 1;
    if (ct_wren && ct_addr == 8'h00) n_len_wr <= n_len_wr + 1;
    if (ct_wren && ct_addr == 8'hFF) n_ct255 <= n_ct255 + 1;
    if (s_wren) n_s_wr <= n_s_wr + 1;
    if (s_wren && ct_wren) n_both <= n_both + 1;
  end
  assign s_rddata  = s_mem[s_q];
  assign pt_rddata = pt_mem[pt_q];

  task automatic load_ksa(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] j, t;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int i = 0; i < 256; i++) s_mem[i] = 8'(i);
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      j = j + s_mem[i] + kb[i % 3];
      t = s_mem[i]; s_mem[i] = s_mem[j]; s_mem[j] = t;
    end
  endtask

  task automatic load_known();
    load_ksa(24'h4B6579);
    for (int i = 0; i < 10; i++) pt_mem[i] = kv_pt[i];
    for (int i = 0; i < 256; i++) ct_mem[i] = 8'hEE;
  endtask

  function automatic int known_mismatches();
    int m = 0;
    for (int i = 0; i < 10; i++) if (ct_mem[i] !== kv_ct[i]) m++;
    return m;
  endfunction

  task automatic start_run();
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  // Wait for rdy; last_ok says whether the cycle before rdy wrote ct[last_addr].
  task automatic wait_done(input int budget, input logic [7:0] last_addr,
                           output int cycles, output bit timed_out, output bit last_ok);
    bit prev_last = 1'b0;
    bit fin = 1'b0;
    cycles = 0; timed_out = 1'b0; last_ok = 1'b0;
    while (!fin) begin
      @(negedge clk); cycles++;
      if (rdy) begin
        last_ok = prev_last; fin = 1'b1;
      end else if (cycles >= budget) begin
        timed_out = 1'b1; fin = 1'b1;
      end
      prev_last = ct_wren && (ct_addr == last_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rdy, s_wren, ct_wren} !== 3'b100) begin
      bad++; $display("FAIL reset_flags got=%b want=100", {rdy, s_wren, ct_wren});
    end
    total++;
    if ({s_addr, pt_addr, ct_addr, s_wrdata, ct_wrdata} !== 40'd0) begin
      bad++; $display("FAIL reset_buses got=%h want=0", {s_addr, pt_addr, ct_addr, s_wrdata, ct_wrdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vector();
    int cyc, ct0, s0, b0, m; bit to, lok;
    load_known();
    ct0 = n_ct_wr; s0 = n_s_wr; b0 = n_both;
    start_run();
    wait_done(400, 8'd9, cyc, to, lok);
    total++;
    if (to) begin bad++; $display("FAIL known_timeout cycles=%0d", cyc); end
    m = known_mismatches();
    total++;
    if (m !== 0) begin
      bad++; $display("FAIL known_ct mismatches=%0d ct1=%h want=%h ct9=%h want=%h", m, ct_mem[1], kv_ct[1], ct_mem[9], kv_ct[9]);
    end
    total++;
    if (n_ct_wr - ct0 !== 10) begin bad++; $display("FAIL known_ct_writes got=%0d want=10", n_ct_wr - ct0); end
    total++;
    if (n_s_wr - s0 !== 18) begin bad++; $display("FAIL known_s_writes got=%0d want=18", n_s_wr - s0); end
    total++;
    if (!lok) begin bad++; $display("FAIL known_rdy_after_last got=0 want=1"); end
    total++;
    if (n_both - b0 !== 0) begin bad++; $display("FAIL known_dual_wren got=%0d want=0", n_both - b0); end
  endtask

  task automatic test_len_zero();
    int cyc, ct0, s0; bit to, lok;
    load_ksa(24'h4B6579);
    pt_mem[0] = 8'h00;
    ct_mem[0] = 8'hEE;
    ct0 = n_ct_wr; s0 = n_s_wr;
    start_run();
    wait_done(20, 8'd0, cyc, to, lok);
    total++;
    if (to || cyc + 1 > 5) begin bad++; $display("FAIL len0_latency got=%0d want<=5", cyc + 1); end
    total++;
    if (ct_mem[0] !== 8'h00) begin bad++; $display("FAIL len0_ct0 got=%h want=00", ct_mem[0]); end
    total++;
    if (n_ct_wr - ct0 !== 1) begin bad++; $display("FAIL len0_ct_writes got=%0d want=1", n_ct_wr - ct0); end
    total++;
    if (n_s_wr - s0 !== 0) begin bad++; $display("FAIL len0_s_writes got=%0d want=0", n_s_wr - s0); end
  endtask

  task automatic test_round_trip();
    int cyc, ct0, c255, l0, m; bit to, lok;
    pt_mem[0] = 8'd255;
    for (int i = 1; i < 256; i++) begin
      pt_mem[i] = 8'($urandom_range(0, 255));
      orig[i]   = pt_mem[i];
    end
    load_ksa(24'h1A2B3C);
    ct0 = n_ct_wr; c255 = n_ct255; l0 = n_len_wr;
    start_run();
    wait_done(5000, 8'd255, cyc, to, lok);
    total++;
    if (to || !lok) begin bad++; $display("FAIL rt_enc_done timeout=%0d last_ok=%0d", to, lok); end
    total++;
    if (n_ct_wr - ct0 !== 256 || n_ct255 - c255 !== 1 || n_len_wr - l0 !== 1) begin
      bad++; $display("FAIL rt_writes total=%0d ct255=%0d ct0=%0d want=256/1/1", n_ct_wr - ct0, n_ct255 - c255, n_len_wr - l0);
    end
    // Decrypt: same key, ciphertext fed back in as plaintext.
    for (int i = 0; i < 256; i++) pt_mem[i] = ct_mem[i];
    for (int i = 0; i < 256; i++) ct_mem[i] = 8'h00;
    load_ksa(24'h1A2B3C);
    start_run();
    wait_done(5000, 8'd255, cyc, to, lok);
    m = 0;
    for (int i = 1; i < 256; i++) if (ct_mem[i] !== orig[i]) m++;
    total++;
    if (to || m !== 0 || ct_mem[0] !== 8'd255) begin
      bad++; $display("FAIL rt_decrypt mismatches=%0d len=%h want=0/ff timeout=%0d", m, ct_mem[0], to);
    end
  endtask

  task automatic test_handshake();
    int cyc, l0, m; bit to, lok, busy, fin;
    // en held high through a whole run
    load_known();
    l0 = n_len_wr; cyc = 0; busy = 1'b0; fin = 1'b0; to = 1'b0;
    @(negedge clk); en = 1'b1;
    while (!fin) begin
      @(negedge clk); cyc++;
      if (!rdy) busy = 1'b1;
      else if (busy) fin = 1'b1;
      if (cyc > 400) begin to = 1'b1; fin = 1'b1; end
    end
    en = 1'b0;
    m = known_mismatches();
    total++;
    if (to || n_len_wr - l0 !== 1 || m !== 0) begin
      bad++; $display("FAIL hs_held runs=%0d want=1 mismatches=%0d timeout=%0d", n_len_wr - l0, m, to);
    end
    repeat (4) @(negedge clk);
    total++;
    if (rdy !== 1'b1 || n_len_wr - l0 !== 1) begin
      bad++; $display("FAIL hs_idle_after rdy=%b runs=%0d want=1/1", rdy, n_len_wr - l0);
    end
    // en pulsed while busy is ignored
    load_known();
    l0 = n_len_wr;
    start_run();
    repeat (6) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    wait_done(400, 8'd9, cyc, to, lok);
    repeat (3) @(negedge clk);
    m = known_mismatches();
    total++;
    if (to || n_len_wr - l0 !== 1 || m !== 0 || rdy !== 1'b1) begin
      bad++; $display("FAIL hs_busy_pulse runs=%0d mismatches=%0d rdy=%b want=1/0/1", n_len_wr - l0, m, rdy);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, m; bit to, lok, seen;
    load_known();
    start_run();
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk); cyc++;
      if (ct_wren && ct_addr == 8'd3) seen = 1'b1;
    end
    @(negedge clk);
    total++;
    if (!seen || rdy !== 1'b0) begin bad++; $display("FAIL mid_busy seen=%0d rdy=%b want=1/0", seen, rdy); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdy, s_wren, ct_wren} !== 3'b100) begin
      bad++; $display("FAIL mid_reset_flags got=%b want=100", {rdy, s_wren, ct_wren});
    end
    @(negedge clk); rst_n = 1'b1;
    load_known();
    start_run();
    wait_done(400, 8'd9, cyc, to, lok);
    m = known_mismatches();
    total++;
    if (to || m !== 0) begin bad++; $display("FAIL mid_rerun mismatches=%0d timeout=%0d want=0/0", m, to); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      s_mem[i] = 8'h00; pt_mem[i] = 8'h00; ct_mem[i] = 8'h00;
    end
    test_reset();
    test_known_vector();
    test_len_zero();
    test_round_trip();
    test_handshake();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
